// File: rtl/fp_sqrt_sched.sv
// fp_sqrt_sched: sequencing and sharing controller for a combinational single-precision
// square-root datapath.
//
// Requesters are arbitrated round-robin. The chosen operand is registered onto dp_a_o and
// held for SETTLE cycles before dp_s_i is captured. The result is then returned on a
// tagged valid/ready response channel. Special operands (NaN, zero/denormal, negative,
// +inf) never enter the datapath. Their result comes from a fixed table and is returned
// on the next cycle.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous reset, active-high
//   req_valid_i  per-requester request valid
//   req_data_i   operands, requester i on bits [32*i+31:32*i]
//   req_ready_o  one-hot grant (IDLE only)
//   rsp_valid_o  response valid
//   rsp_id_o     requester index of the response
//   rsp_data_o   square-root result
//   rsp_ready_i  response accepted
//   dp_a_o       operand to the external datapath (always the operand register)
//   dp_s_i       datapath result, combinational from dp_a_o
//   busy_o       high whenever the controller is not idle
module fp_sqrt_sched #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned SETTLE = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_REQ-1:0]      req_valid_i,
  input  logic [32*N_REQ-1:0]   req_data_i,
  output logic [N_REQ-1:0]      req_ready_o,
  output logic                  rsp_valid_o,
  output logic [2:0]            rsp_id_o,
  output logic [31:0]           rsp_data_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           dp_a_o,
  input  logic [31:0]           dp_s_i,
  output logic                  busy_o
);

  localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned SumW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q;
  logic [PtrW-1:0]   rr_ptr_q;
  logic [PtrW-1:0]   id_q;
  logic [31:0]       op_q;
  logic [31:0]       res_q;
  logic [3:0]        cnt_q;

  // Round-robin arbiter: first valid requester at or after rr_ptr_q, with wrap-around.
  logic [N_REQ-1:0]  grant;
  logic [PtrW-1:0]   gnt_idx;
  logic              gnt_any;
  logic [SumW-1:0]   sum;
  logic [PtrW-1:0]   idx;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + SumW'(k);
      if (sum >= SumW'(N_REQ)) begin
        sum = sum - SumW'(N_REQ);
      end
      idx = sum[PtrW-1:0];
      if (!gnt_any && req_valid_i[idx]) begin
        grant[idx] = 1'b1;
        gnt_idx    = idx;
        gnt_any    = 1'b1;
      end
    end
  end

  // A grant is only offered in IDLE and never while reset is asserted.
  logic accept;
  assign accept      = (state_q == StIdle) && gnt_any && !rst_i;
  assign req_ready_o = accept ? grant : '0;

  // Operand of the granted requester.
  logic [31:0] sel_op;
  always_comb begin
    sel_op = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_op = req_data_i[32*i +: 32];
      end
    end
  end

  // Special-operand classification. The first matching rule wins.
  logic        spec_hit;
  logic [31:0] spec_val;
  logic [7:0]  sel_exp;
  logic [22:0] sel_frac;

  always_comb begin
    sel_exp  = sel_op[30:23];
    sel_frac = sel_op[22:0];
    spec_hit = 1'b1;
    spec_val = '0;
    if (sel_exp == 8'hFF && sel_frac != '0) begin
      spec_val = sel_op | 32'h0040_0000;       // quiet the NaN, keep its payload
    end else if (sel_exp == 8'h00) begin
      spec_val = {sel_op[31], 31'b0};          // denormals flush to signed zero
    end else if (sel_op[31]) begin
      spec_val = 32'h7FC0_0000;                // sqrt of negative -> canonical qNaN
    end else if (sel_exp == 8'hFF) begin
      spec_val = 32'h7F80_0000;
    end else begin
      spec_hit = 1'b0;
    end
  end

  logic [PtrW-1:0] ptr_next;
  assign ptr_next = (gnt_idx == PtrW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      id_q     <= '0;
      op_q     <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            op_q     <= sel_op;
            id_q     <= gnt_idx;
            rr_ptr_q <= ptr_next;
            if (spec_hit) begin
              res_q   <= spec_val;
              state_q <= StResp;
            end else begin
              cnt_q   <= 4'(SETTLE - 1);
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          // dp_a_o has been stable for SETTLE cycles when cnt_q reaches zero.
          if (cnt_q == 4'd0) begin
            res_q   <= dp_s_i;
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rsp_valid_o = (state_q == StResp);
  assign rsp_id_o    = 3'(id_q);
  assign rsp_data_o  = res_q;
  assign dp_a_o      = op_q;
  assign busy_o      = (state_q != StIdle);

endmodule
